gpio_apb_banked: RTL and testbench
==================================

Name: gpio_apb_banked

Overview:
- Parametrised successor to the current GPIO block inside the IO subsystem. Supports any pin count through 32-pin register banks.
- Adds atomic set/clear of outputs, per-pin interrupt mode, and sticky W1C status.
- Hangs off the IO subsystem's GPIO APB port. Drives pad tx enables and outputs, and raises one aggregated interrupt to the event unit.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width.
- NUM_GPIOS, 64, number of pins (1..256).
- SYNC_STAGES, 2, input synchroniser depth (≥2).
- Derived: NUM_BANKS = ceil(NUM_GPIOS/32).

Ports:
- sys_clk_i  in  1  single clock.
- sys_rst_i  in  1  asynchronous, active-high reset.
- gpio_apb_paddr  in  APB_ADDR_WIDTH  APB address.
- gpio_apb_pwdata  in  32  write data.
- gpio_apb_pwrite  in  1  write strobe.
- gpio_apb_psel  in  1  select.
- gpio_apb_penable  in  1  access phase.
- gpio_apb_prdata  out  32  read data.
- gpio_apb_pready  out  1  ready.
- gpio_apb_pslverr  out  1  error.
- gpio_in  in  NUM_GPIOS  pad inputs (asynchronous).
- gpio_out  out  NUM_GPIOS  pad output values.
- gpio_tx_en_o  out  NUM_GPIOS  pad output enables.
- gpio_in_sync_o  out  NUM_GPIOS  synchronised (filtered, if enabled) inputs.
- gpio_interrupt_o  out  1  aggregated interrupt, registered.

Behaviour:
- Reset (sys_rst_i=1, async): all registers 0.
  - gpio_out, gpio_tx_en_o, gpio_in_sync_o, gpio_interrupt_o, gpio_apb_prdata, gpio_apb_pslverr = 0.
  - Synchroniser flops = 0. No spurious edge is taken on the first cycle after release.
- Addressing: bank = paddr[8:6], reg = paddr[5:2]. Pin index = bank*32 + bit.
- Registers per bank:
  - 0x0 DIR RW.
  - 0x4 OUT RW.
  - 0x8 IN RO (gpio_in_sync_o slice).
  - 0xC SET W1S on OUT, reads 0.
  - 0x10 CLR W1C on OUT, reads 0.
  - 0x14 INT_EN RW.
  - 0x18 INT_TYPE RW (0 level, 1 edge).
  - 0x1C INT_POL RW (level: 1=high/0=low; edge: 1=rise/0=fall).
  - 0x20 INT_STATUS RW1C.
  - 0x24 DEBOUNCE (global, bank 0 only, see optional feature).
- Bits at or above NUM_GPIOS in the last bank: read 0, ignore writes.
- APB:
  - Zero wait states; gpio_apb_pready tied 1.
  - Write commits on psel&penable&pwrite.
  - prdata is combinational from the decoded register during the access phase, 0 otherwise.
  - pslverr=1 in the access phase for bank ≥ NUM_BANKS, reg > 0x24, or 0x24 in bank ≠ 0. Erroneous writes have no effect.
- Input path:
  - SYNC_STAGES-flop synchroniser per pin, then optional filter.
  - Result s_in feeds gpio_in_sync_o and an s_prev register.
  - Edge latency: gpio_in change → INT_STATUS set after SYNC_STAGES+1 cycles (filter off).
- Interrupt event for pin i:
  - Edge mode: INT_POL ? (s_in & ~s_prev) : (~s_in & s_prev).
  - Level mode: s_in == INT_POL.
  - INT_STATUS[i] sets when event & INT_EN[i].
- Interrupt output:
  - gpio_interrupt_o = register of OR(INT_STATUS) over all banks; one cycle after the status change.
- Simultaneous events:
  - Status set and W1C on the same pin in the same cycle: set wins.
  - Level mode with the level still present: status re-asserts the cycle after clear.
  - SET and CLR only touch the addressed register, so they cannot collide in one APB transfer.
- Pin mapping: gpio_out = OUT, gpio_tx_en_o = DIR, each directly from flops. Writing INT_EN=0 does not clear pending status.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - DEBOUNCE[15:0] is a prescaler reload value.
  - A free-running 16-bit counter emits a tick when it reaches DEBOUNCE, then reloads 0.
  - On each tick, each pin compares the synchroniser output with its filtered value s_in, using a per-pin 2-bit counter.
  - s_in flips after 3 consecutive ticks of disagreement; agreement resets the counter.
  - DEBOUNCE=0 means tick every cycle.
  - Reset: counters 0, s_in 0.
- Undefined:
  - s_in = synchroniser output.
  - 0x24 reads 0, with no pslverr.
  - No filter logic is instantiated.

Test Plan:
- Reset mid-operation: DIR=0xFFFF_FFFF, OUT=0xA5A5_A5A5 in bank 0, then assert sys_rst_i asynchronously → gpio_out=0 and gpio_tx_en_o=0 immediately, all reads return 0 after release.
- Atomic output: OUT=0x0000_00F0 in bank 1, then SET 0x0F, then CLR 0x80 → OUT reads 0x0000_007F and gpio_out[63:32]=0x7F.
- Edge interrupt: pin 40, INT_EN=1, TYPE=1, POL=1, drive gpio_in[40] 0→1 → INT_STATUS bank1 bit8 set after 3 cycles, gpio_interrupt_o=1 one cycle later. W1C 0x100 → irq drops.
- Level re-assert and collision: pin 3 level-high held at 1, W1C bit3 → status reads 1 again next cycle. Edge event coincident with W1C → status stays 1.
- Address errors: access bank 2 (paddr 0x80) with NUM_GPIOS=64, or reg 0x28 → pslverr=1, prdata=0, no register change.
- GPIO_DEBOUNCE_EN with DEBOUNCE=3: a 10-cycle glitch on pin 0 → no status or gpio_in_sync_o change. A 20-cycle stable high → gpio_in_sync_o[0]=1 after the 3rd tick.

Source files
------------

// File: rtl/gpio_apb_banked.sv
// gpio_apb_banked: APB GPIO organised in 32-pin banks with atomic set/clear,
// per-pin level/edge interrupts, sticky W1C status and one aggregated irq.
// Optional input debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module gpio_apb_banked #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_GPIOS      = 64,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      sys_clk_i,
   input  logic                      sys_rst_i,
   input  logic [APB_ADDR_WIDTH-1:0] gpio_apb_paddr,
   input  logic [31:0]               gpio_apb_pwdata,
   input  logic                      gpio_apb_pwrite,
   input  logic                      gpio_apb_psel,
   input  logic                      gpio_apb_penable,
   output logic [31:0]               gpio_apb_prdata,
   output logic                      gpio_apb_pready,
   output logic                      gpio_apb_pslverr,
   input  logic [NUM_GPIOS-1:0]      gpio_in,
   output logic [NUM_GPIOS-1:0]      gpio_out,
   output logic [NUM_GPIOS-1:0]      gpio_tx_en_o,
   output logic [NUM_GPIOS-1:0]      gpio_in_sync_o,
   output logic                      gpio_interrupt_o
);

   localparam int NUM_BANKS = (NUM_GPIOS + 31) / 32;
   localparam int W         = NUM_BANKS * 32;

   typedef enum logic [3:0] {
      REG_DIR        = 4'd0,
      REG_OUT        = 4'd1,
      REG_IN         = 4'd2,
      REG_SET        = 4'd3,
      REG_CLR        = 4'd4,
      REG_INT_EN     = 4'd5,
      REG_INT_TYPE   = 4'd6,
      REG_INT_POL    = 4'd7,
      REG_INT_STATUS = 4'd8,
      REG_DEBOUNCE   = 4'd9
   } reg_e;

   logic [W-1:0] dir_q, dir_d, out_q, out_d, en_q, en_d;
   logic [W-1:0] type_q, type_d, pol_q, pol_d, status_q, status_d;
   logic [W-1:0] s_prev_q, s_prev_d;
   logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
   logic         irq_q, irq_d;

   logic [W-1:0] pin_mask, gpio_in_w, sync_out, s_in, event_w, w1c;
   logic [2:0]   bank;
   reg_e         reg_sel;
   logic         access, bank_ok, reg_ok, err, wr;
   logic [31:0]  rdata;
   logic         unused_addr;

`ifdef GPIO_DEBOUNCE_EN
   logic [15:0]         deb_q, deb_d, tick_cnt_q, tick_cnt_d;
   logic [W-1:0][1:0]   deb_cnt_q, deb_cnt_d;
   logic [W-1:0]        filt_q, filt_d;
   logic                tick;
`endif

   assign bank        = gpio_apb_paddr[8:6];
   assign reg_sel     = reg_e'(gpio_apb_paddr[5:2]);
   assign unused_addr = ^{gpio_apb_paddr[1:0], gpio_apb_paddr[APB_ADDR_WIDTH-1:9]};

   // Pin validity mask and zero-padded input bus covering whole banks
   always_comb begin
      gpio_in_w = '0;
      gpio_in_w[NUM_GPIOS-1:0] = gpio_in;
      for (int unsigned i = 0; i < W; i++) pin_mask[i] = (i < NUM_GPIOS);
   end

   // APB decode: out-of-range bank, unknown register, or DEBOUNCE outside bank 0
   always_comb begin
      access  = gpio_apb_psel & gpio_apb_penable;
      bank_ok = (32'(bank) < 32'(NUM_BANKS));
      reg_ok  = (gpio_apb_paddr[5:2] <= 4'd9) &&
                !((gpio_apb_paddr[5:2] == 4'd9) && (bank != 3'd0));
      err     = access & ~(bank_ok & reg_ok);
      wr      = access & gpio_apb_pwrite & ~err;
   end

   // Synchroniser shift chain
   always_comb begin
      sync_d[0] = gpio_in_w;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
      sync_out = sync_q[SYNC_STAGES-1];
   end

`ifdef GPIO_DEBOUNCE_EN
   // Debounce: prescaler tick, then s_in flips after 3 consecutive disagreeing ticks
   always_comb begin
      tick       = (tick_cnt_q == deb_q);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
      filt_d     = filt_q;
      deb_cnt_d  = deb_cnt_q;
      if (tick) begin
         for (int unsigned i = 0; i < W; i++) begin
            if (sync_out[i] != filt_q[i]) begin
               if (deb_cnt_q[i] == 2'd2) begin
                  filt_d[i]    = ~filt_q[i];
                  deb_cnt_d[i] = '0;
               end else begin
                  deb_cnt_d[i] = deb_cnt_q[i] + 2'd1;
               end
            end else begin
               deb_cnt_d[i] = '0;
            end
         end
      end
      s_in = filt_q;
   end
`else
   // No filter: the synchroniser output is the pin state
   always_comb s_in = sync_out;
`endif

   // Register writes, interrupt events and sticky status (set beats W1C)
   always_comb begin
      dir_d  = dir_q;
      out_d  = out_q;
      en_d   = en_q;
      type_d = type_q;
      pol_d  = pol_q;
      w1c    = '0;
`ifdef GPIO_DEBOUNCE_EN
      deb_d  = deb_q;
`endif
      if (wr) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank == 3'(b)) begin
               case (reg_sel)
                  REG_DIR:        dir_d[b*32 +: 32]  = gpio_apb_pwdata;
                  REG_OUT:        out_d[b*32 +: 32]  = gpio_apb_pwdata;
                  REG_SET:        out_d[b*32 +: 32]  = out_q[b*32 +: 32] | gpio_apb_pwdata;
                  REG_CLR:        out_d[b*32 +: 32]  = out_q[b*32 +: 32] & ~gpio_apb_pwdata;
                  REG_INT_EN:     en_d[b*32 +: 32]   = gpio_apb_pwdata;
                  REG_INT_TYPE:   type_d[b*32 +: 32] = gpio_apb_pwdata;
                  REG_INT_POL:    pol_d[b*32 +: 32]  = gpio_apb_pwdata;
                  REG_INT_STATUS: w1c[b*32 +: 32]    = gpio_apb_pwdata;
`ifdef GPIO_DEBOUNCE_EN
                  REG_DEBOUNCE:   deb_d              = gpio_apb_pwdata[15:0];
`endif
                  default: ;
               endcase
            end
         end
      end
      dir_d    = dir_d  & pin_mask;
      out_d    = out_d  & pin_mask;
      en_d     = en_d   & pin_mask;
      type_d   = type_d & pin_mask;
      pol_d    = pol_d  & pin_mask;
      event_w  = (type_q  & ((pol_q & s_in & ~s_prev_q) | (~pol_q & ~s_in & s_prev_q))) |
                 (~type_q & ~(s_in ^ pol_q));
      status_d = ((status_q & ~w1c) | (event_w & en_q)) & pin_mask;
      s_prev_d = s_in;
      irq_d    = |status_q;
   end

   // Read mux: combinational during a valid access phase, zero otherwise
   always_comb begin
      rdata = '0;
      if (access && !err) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank == 3'(b)) begin
               case (reg_sel)
                  REG_DIR:        rdata = dir_q[b*32 +: 32];
                  REG_OUT:        rdata = out_q[b*32 +: 32];
                  REG_IN:         rdata = s_in[b*32 +: 32] & pin_mask[b*32 +: 32];
                  REG_INT_EN:     rdata = en_q[b*32 +: 32];
                  REG_INT_TYPE:   rdata = type_q[b*32 +: 32];
                  REG_INT_POL:    rdata = pol_q[b*32 +: 32];
                  REG_INT_STATUS: rdata = status_q[b*32 +: 32];
`ifdef GPIO_DEBOUNCE_EN
                  REG_DEBOUNCE:   rdata = {16'd0, deb_q};
`endif
                  default:        rdata = '0;
               endcase
            end
         end
      end
   end

   // State registers
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         dir_q    <= '0;
         out_q    <= '0;
         en_q     <= '0;
         type_q   <= '0;
         pol_q    <= '0;
         status_q <= '0;
         s_prev_q <= '0;
         sync_q   <= '0;
         irq_q    <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
         deb_q      <= '0;
         tick_cnt_q <= '0;
         deb_cnt_q  <= '0;
         filt_q     <= '0;
`endif
      end else begin
         dir_q    <= dir_d;
         out_q    <= out_d;
         en_q     <= en_d;
         type_q   <= type_d;
         pol_q    <= pol_d;
         status_q <= status_d;
         s_prev_q <= s_prev_d;
         sync_q   <= sync_d;
         irq_q    <= irq_d;
`ifdef GPIO_DEBOUNCE_EN
         deb_q      <= deb_d;
         tick_cnt_q <= tick_cnt_d;
         deb_cnt_q  <= deb_cnt_d;
         filt_q     <= filt_d;
`endif
      end
   end

   assign gpio_apb_prdata  = rdata;
   assign gpio_apb_pready  = 1'b1;
   assign gpio_apb_pslverr = err;
   assign gpio_out         = out_q[NUM_GPIOS-1:0];
   assign gpio_tx_en_o     = dir_q[NUM_GPIOS-1:0];
   assign gpio_in_sync_o   = s_in[NUM_GPIOS-1:0];
   assign gpio_interrupt_o = irq_q;

endmodule

// File: tb/tb_gpio_apb_banked.sv
// Directed testbench for gpio_apb_banked (NUM_GPIOS=64, SYNC_STAGES=2).
module tb_gpio_apb_banked;

   logic        clk, rst;
   logic [11:0] paddr;
   logic [31:0] pwdata, prdata;
   logic        pwrite, psel, penable, pready, pslverr;
   logic [63:0] gpio_in, gpio_out, tx_en, sync_o;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] rd;
   logic        re, last_err, found, seen;

`ifdef GPIO_DEBOUNCE_EN
   localparam int FL = 3;  // extra filter latency with DEBOUNCE=0
`else
   localparam int FL = 0;
`endif

   gpio_apb_banked #(.APB_ADDR_WIDTH(12), .NUM_GPIOS(64), .SYNC_STAGES(2)) dut (
      .sys_clk_i(clk), .sys_rst_i(rst),
      .gpio_apb_paddr(paddr), .gpio_apb_pwdata(pwdata), .gpio_apb_pwrite(pwrite),
      .gpio_apb_psel(psel), .gpio_apb_penable(penable), .gpio_apb_prdata(prdata),
      .gpio_apb_pready(pready), .gpio_apb_pslverr(pslverr),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_tx_en_o(tx_en),
      .gpio_in_sync_o(sync_o), .gpio_interrupt_o(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      #1 last_err = pslverr;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge clk);
      penable = 1'b1;
      #1 d = prdata; e = pslverr;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; gpio_in = '0; last_err = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_gpio_out", gpio_out, 64'h0);
      check("rst_tx_en", tx_en, 64'h0);
      check("rst_sync", sync_o, 64'h0);
      check("rst_irq", {63'h0, irq}, 64'h0);
      check("rst_prdata", {32'h0, prdata}, 64'h0);
      check("rst_pslverr", {63'h0, pslverr}, 64'h0);
      check("pready", {63'h0, pready}, 64'h1);

      // Reset mid-operation
      apb_write(12'h000, 32'hFFFF_FFFF);
      apb_write(12'h004, 32'hA5A5_A5A5);
      check("mid_tx_en", tx_en, 64'h0000_0000_FFFF_FFFF);
      check("mid_gpio_out", gpio_out, 64'h0000_0000_A5A5_A5A5);
      #3 rst = 1'b1;
      #1 check("async_rst_out", gpio_out, 64'h0);
      check("async_rst_tx_en", tx_en, 64'h0);
      @(negedge clk); rst = 1'b0;
      apb_read(12'h000, rd, re); check("post_rst_dir", {32'h0, rd}, 64'h0);
      apb_read(12'h004, rd, re); check("post_rst_out", {32'h0, rd}, 64'h0);

      // Atomic set/clear on bank 1
      apb_write(12'h044, 32'h0000_00F0);
      apb_write(12'h04C, 32'h0000_000F);
      apb_write(12'h050, 32'h0000_0080);
      apb_read(12'h044, rd, re); check("atomic_out_rd", {32'h0, rd}, 64'h7F);
      check("atomic_gpio_out", gpio_out, 64'h0000_007F_0000_0000);
      apb_read(12'h04C, rd, re); check("set_reads0", {32'h0, rd}, 64'h0);
      apb_read(12'h050, rd, re); check("clr_reads0", {32'h0, rd}, 64'h0);

      // Edge interrupt on pin 40 (bank 1 bit 8), rising
      apb_write(12'h058, 32'h100);
      apb_write(12'h05C, 32'h100);
      apb_write(12'h054, 32'h100);
      @(negedge clk); gpio_in[40] = 1'b1;
      @(negedge clk);
      repeat (FL) @(negedge clk);
      @(negedge clk);
      check("edge_sync40", {63'h0, sync_o[40]}, 64'h1);
      check("edge_irq_k1", {63'h0, irq}, 64'h0);
      @(negedge clk); check("edge_irq_k2", {63'h0, irq}, 64'h0);
      @(negedge clk); check("edge_irq_k3", {63'h0, irq}, 64'h1);
      apb_read(12'h060, rd, re); check("edge_status", {32'h0, rd}, 64'h100);
      apb_read(12'h048, rd, re); check("in_bank1", {32'h0, rd}, 64'h100);
      apb_write(12'h060, 32'h100);
      check("w1c_irq_lag", {63'h0, irq}, 64'h1);
      @(negedge clk); check("w1c_irq_drop", {63'h0, irq}, 64'h0);
      apb_read(12'h060, rd, re); check("w1c_status", {32'h0, rd}, 64'h0);

      // Level re-assert on pin 3 and edge/W1C collision on pin 4
      gpio_in[3] = 1'b1;
      apb_write(12'h01C, 32'h18);
      apb_write(12'h018, 32'h10);
      apb_write(12'h014, 32'h18);
      apb_read(12'h020, rd, re); check("level_status", {32'h0, rd}, 64'h08);
      apb_write(12'h020, 32'h08);
      apb_read(12'h020, rd, re); check("level_reassert", {32'h0, rd}, 64'h08);
      check("level_irq", {63'h0, irq}, 64'h1);
      @(negedge clk); gpio_in[4] = 1'b1;
      repeat (4 + FL) @(negedge clk);
      apb_read(12'h020, rd, re); check("edge4_status", {32'h0, rd}, 64'h18);
      gpio_in[4] = 1'b0;
      repeat (4 + FL) @(negedge clk);
      apb_write(12'h020, 32'h10);
      apb_read(12'h020, rd, re); check("edge4_w1c", {32'h0, rd}, 64'h08);
      gpio_in[4] = 1'b1;
      repeat (FL) @(negedge clk);
      apb_write(12'h020, 32'h10);
      apb_read(12'h020, rd, re); check("collision_set_wins", {32'h0, rd}, 64'h18);
      apb_write(12'h014, 32'h08);
      apb_read(12'h020, rd, re); check("en_off_keeps_status", {32'h0, rd}, 64'h18);

      // Address errors
      apb_read(12'h080, rd, re);
      check("bank2_err", {63'h0, re}, 64'h1);
      check("bank2_rdata", {32'h0, rd}, 64'h0);
      apb_read(12'h028, rd, re);
      check("reg28_err", {63'h0, re}, 64'h1);
      check("reg28_rdata", {32'h0, rd}, 64'h0);
      apb_write(12'h034, 32'hFFFF_FFFF);
      check("reg34_wr_err", {63'h0, last_err}, 64'h1);
      apb_read(12'h014, rd, re);
      check("reg34_no_alias", {32'h0, rd}, 64'h08);
      check("ok_read_noerr", {63'h0, re}, 64'h0);
      apb_write(12'h064, 32'h3);
      check("deb_bank1_err", {63'h0, last_err}, 64'h1);
      apb_read(12'h024, rd, re);
      check("deb_bank0_noerr", {63'h0, re}, 64'h0);
      check("deb_bank0_rd", {32'h0, rd}, 64'h0);

`ifdef GPIO_DEBOUNCE_EN
      // Debounce with DEBOUNCE=3 (tick every 4 cycles) on pin 0, rising-edge irq
      apb_write(12'h018, 32'h11);
      apb_write(12'h01C, 32'h19);
      apb_write(12'h014, 32'h09);
      apb_write(12'h024, 32'h3);
      apb_read(12'h024, rd, re); check("deb_rd", {32'h0, rd}, 64'h3);
      gpio_in[0] = 1'b1;
      repeat (8) @(negedge clk); check("deb_early", {63'h0, sync_o[0]}, 64'h0);
      repeat (12) @(negedge clk); check("deb_stable_high", {63'h0, sync_o[0]}, 64'h1);
      apb_read(12'h020, rd, re); check("deb_status_rise", {63'h0, rd[0]}, 64'h1);
      apb_write(12'h020, 32'h1);
      // locate a tick edge by the falling flip, then glitch between ticks
      gpio_in[0] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (sync_o[0] == 1'b0) found = 1'b1;
      end
      check("deb_fall_found", {63'h0, found}, 64'h1);
      repeat (3) @(negedge clk);
      gpio_in[0] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | sync_o[0];
      end
      gpio_in[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | sync_o[0];
      end
      check("deb_glitch_sync", {63'h0, seen}, 64'h0);
      apb_read(12'h020, rd, re); check("deb_glitch_status", {63'h0, rd[0]}, 64'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
